reg_dump_ctrl: RTL

Debug readout sequencer for the MIPS register bank. On a start request it walks all register addresses in order, reads each 32-bit word through a dedicated combinational read port, and streams it as four bytes (MSB first) to the debug UART transmitter over a valid/ready handshake. It sits between the debug unit's command decoder and the UART TX path, and is the only driver of the register bank's debug read address.

---
 rtl/reg_dump_ctrl.sv | 105 ++++++++++
 1 files changed

// File: rtl/reg_dump_ctrl.sv
// Debug readout sequencer: walks the register bank in ascending address order
// and streams each word MSB-first as bytes over a valid/ready handshake.
module reg_dump_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int NREGS      = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_start,
    output logic [ADDR_WIDTH-1:0] o_reg_addr,
    input  logic [DATA_WIDTH-1:0] i_reg_data,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NREGS - 1);
    localparam logic [CNT_W-1:0]      LAST_BYTE = CNT_W'(NBYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        SEND,
        NEXT,
        DONE
    } state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic [DATA_WIDTH-1:0]   word_reg, word_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            word_reg  <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            word_reg  <= word_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        word_next  = word_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                addr_next = '0;
                if (i_start) begin
                    state_next = READ;
                end
            end
            READ: begin
                // The word is sampled exactly once; bytes in flight ignore later bank writes.
                word_next  = i_reg_data;
                cnt_next   = '0;
                state_next = SEND;
            end
            SEND: begin
                if (i_tx_ready) begin
                    word_next = word_reg << 8;
                    cnt_next  = cnt_reg + 1'b1;
                    if (cnt_reg == LAST_BYTE) begin
                        state_next = NEXT;
                    end
                end
            end
            NEXT: begin
                if (addr_reg == LAST_ADDR) begin
                    state_next = DONE;
                end else begin
                    addr_next  = addr_reg + 1'b1;
                    state_next = READ;
                end
            end
            DONE: begin
                addr_next  = '0;
                state_next = IDLE;
            end
            default: begin
                addr_next  = '0;
                state_next = IDLE;
            end
        endcase
    end

    // Outputs decode straight from registers, so valid/data stay stable while stalled.
    assign o_reg_addr = addr_reg;
    assign o_tx_data  = word_reg[DATA_WIDTH-1 -: 8];
    assign o_tx_valid = (state_reg == SEND);
    assign o_busy     = (state_reg != IDLE);
    assign o_done     = (state_reg == DONE);

endmodule
